// File: rtl/v_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : v_bridge_pkg
// Description : Shared types for the scalar-to-vector request bridge. Holds the
//               CSR snapshot and request record carried alongside each
//               instruction.
// Revision    : 1.0 - initial release
// ============================================================================
package v_bridge_pkg;

  localparam int VL_W    = 10;
  localparam int VLMUL_W = 3;
  localparam int VSEW_W  = 2;
  localparam int VXRM_W  = 2;

  // CSR state captured at dispatch so V sees the configuration the
  // instruction was issued under, not whatever the core holds later.
  typedef struct packed {
    logic [VL_W-1:0]    vl;
    logic [VL_W-1:0]    vStart;
    logic [VLMUL_W-1:0] vlmul;
    logic [VSEW_W-1:0]  vSew;
    logic [VXRM_W-1:0]  vxrm;
    logic               vta;
    logic               vma;
  } csr_snapshot_t;

  typedef struct packed {
    logic [31:0]   inst;
    logic [31:0]   src1Data;
    csr_snapshot_t csr;
  } v_req_t;

endpackage
`default_nettype wire

// File: rtl/v_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : v_sync_fifo
// Description : Synchronous FIFO with count output and flush. Output is the
//               registered head slot; there is no fall-through path.
// Revision    : 1.0 - initial release
// ============================================================================
module v_sync_fifo #(
  parameter int WIDTH = 94,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;

  // Pointer/count next state; DEPTH is a power of two so pointers wrap
  // naturally, and full/empty is decided from the count alone.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push_i) - CW'(pop_i);
    if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Control state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents are intentionally not reset.
  always_ff @(posedge clock) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/v_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : v_issue_queue
// Description : Request buffer in front of vector unit V. Queues instructions
//               with rs1 data and CSR snapshot, presents the head to V, and
//               throttles issue on an outstanding-response credit limit.
// Revision    : 1.0 - initial release
// ============================================================================
module v_issue_queue
  import v_bridge_pkg::*;
#(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                                 clock,
  input  logic                                 reset,
  output logic                                 enq_ready,
  input  logic                                 enq_valid,
  input  logic [31:0]                          enq_bits_inst,
  input  logic [31:0]                          enq_bits_src1Data,
  input  logic [9:0]                           enq_csr_vl,
  input  logic [9:0]                           enq_csr_vStart,
  input  logic [2:0]                           enq_csr_vlmul,
  input  logic [1:0]                           enq_csr_vSew,
  input  logic [1:0]                           enq_csr_vxrm,
  input  logic                                 enq_csr_vta,
  input  logic                                 enq_csr_vma,
  input  logic                                 flush,
  input  logic                                 req_ready,
  output logic                                 req_valid,
  output logic [31:0]                          req_bits_inst,
  output logic [31:0]                          req_bits_src1Data,
  output logic [9:0]                           csrInterface_vl,
  output logic [9:0]                           csrInterface_vStart,
  output logic [2:0]                           csrInterface_vlmul,
  output logic [1:0]                           csrInterface_vSew,
  output logic [1:0]                           csrInterface_vxrm,
  output logic                                 csrInterface_vta,
  output logic                                 csrInterface_vma,
  input  logic                                 resp_valid,
  output logic [$clog2(DEPTH):0]               count,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                                 busy,
  output logic                                 err_unexpectedResp
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] C_FULL    = CW'(DEPTH);
  localparam logic [OW-1:0] C_MAX_OUT = OW'(MAX_OUTSTANDING);

  v_req_t        w_enq_req;
  v_req_t        w_head_req;
  logic [CW-1:0] w_count;
  logic          w_enq_fire;
  logic          w_issue_fire;
  logic          w_resp_ok;

  logic [OW-1:0] outstanding_q, outstanding_d;
  logic          err_q, err_d;

  assign w_enq_req.inst         = enq_bits_inst;
  assign w_enq_req.src1Data     = enq_bits_src1Data;
  assign w_enq_req.csr.vl       = enq_csr_vl;
  assign w_enq_req.csr.vStart   = enq_csr_vStart;
  assign w_enq_req.csr.vlmul    = enq_csr_vlmul;
  assign w_enq_req.csr.vSew     = enq_csr_vSew;
  assign w_enq_req.csr.vxrm     = enq_csr_vxrm;
  assign w_enq_req.csr.vta      = enq_csr_vta;
  assign w_enq_req.csr.vma      = enq_csr_vma;

  // Handshakes: enq_ready only looks at local state, never at req_ready.
  assign enq_ready    = !reset && !flush && (w_count != C_FULL);
  assign req_valid    = (w_count != '0) && (outstanding_q != C_MAX_OUT);
  assign w_enq_fire   = enq_valid && enq_ready;
  assign w_issue_fire = req_valid && req_ready;
  assign w_resp_ok    = resp_valid && (outstanding_q != '0);

  v_sync_fifo #(
    .WIDTH ($bits(v_req_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (w_enq_fire),
    .pop_i   (w_issue_fire),
    .flush_i (flush),
    .data_i  (w_enq_req),
    .data_o  (w_head_req),
    .count_o (w_count)
  );

  // Credit and error next state; flush leaves in-flight credits alone since
  // those requests will still respond.
  always_comb begin
    outstanding_d = outstanding_q + OW'(w_issue_fire) - OW'(w_resp_ok);
    err_d         = err_q || (resp_valid && (outstanding_q == '0));
  end

  // Credit counter and sticky error register.
  always_ff @(posedge clock) begin
    if (reset) begin
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  assign req_bits_inst        = w_head_req.inst;
  assign req_bits_src1Data    = w_head_req.src1Data;
  assign csrInterface_vl      = w_head_req.csr.vl;
  assign csrInterface_vStart  = w_head_req.csr.vStart;
  assign csrInterface_vlmul   = w_head_req.csr.vlmul;
  assign csrInterface_vSew    = w_head_req.csr.vSew;
  assign csrInterface_vxrm    = w_head_req.csr.vxrm;
  assign csrInterface_vta     = w_head_req.csr.vta;
  assign csrInterface_vma     = w_head_req.csr.vma;

  assign count              = w_count;
  assign outstanding        = outstanding_q;
  assign busy               = (w_count != '0) || (outstanding_q != '0);
  assign err_unexpectedResp = err_q;

endmodule
`default_nettype wire

// File: tb/tb_v_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_v_issue_queue
// Description : Directed testbench for v_issue_queue with scoreboard on the
//               issue side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_v_issue_queue;
  import v_bridge_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enq_valid = 1'b0;
  logic        flush = 1'b0;
  logic        req_ready = 1'b0;
  logic        resp_valid = 1'b0;
  v_req_t      drv = '0;

  logic        enq_ready, req_valid, busy, err_unexpectedResp;
  logic [31:0] req_bits_inst, req_bits_src1Data;
  logic [9:0]  csr_vl, csr_vStart;
  logic [2:0]  csr_vlmul;
  logic [1:0]  csr_vSew, csr_vxrm;
  logic        csr_vta, csr_vma;
  logic [2:0]  count;
  logic [3:0]  outstanding;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          issued  = 0;
  v_req_t      exp_q[$];

  always #5 clock = ~clock;

  v_issue_queue #(.DEPTH(4), .MAX_OUTSTANDING(8)) dut (
    .clock               (clock),
    .reset               (reset),
    .enq_ready           (enq_ready),
    .enq_valid           (enq_valid),
    .enq_bits_inst       (drv.inst),
    .enq_bits_src1Data   (drv.src1Data),
    .enq_csr_vl          (drv.csr.vl),
    .enq_csr_vStart      (drv.csr.vStart),
    .enq_csr_vlmul       (drv.csr.vlmul),
    .enq_csr_vSew        (drv.csr.vSew),
    .enq_csr_vxrm        (drv.csr.vxrm),
    .enq_csr_vta         (drv.csr.vta),
    .enq_csr_vma         (drv.csr.vma),
    .flush               (flush),
    .req_ready           (req_ready),
    .req_valid           (req_valid),
    .req_bits_inst       (req_bits_inst),
    .req_bits_src1Data   (req_bits_src1Data),
    .csrInterface_vl     (csr_vl),
    .csrInterface_vStart (csr_vStart),
    .csrInterface_vlmul  (csr_vlmul),
    .csrInterface_vSew   (csr_vSew),
    .csrInterface_vxrm   (csr_vxrm),
    .csrInterface_vta    (csr_vta),
    .csrInterface_vma    (csr_vma),
    .resp_valid          (resp_valid),
    .count               (count),
    .outstanding         (outstanding),
    .busy                (busy),
    .err_unexpectedResp  (err_unexpectedResp)
  );

  function automatic v_req_t mk(logic [31:0] inst, logic [31:0] src1, int k);
    v_req_t r;
    logic [3:0] kb;
    kb           = 4'(k);
    r.inst       = inst;
    r.src1Data   = src1;
    r.csr.vl     = 10'(16 + k);
    r.csr.vStart = 10'(k);
    r.csr.vlmul  = 3'(k);
    r.csr.vSew   = kb[1:0];
    r.csr.vxrm   = 2'(k + 1);
    r.csr.vta    = kb[0];
    r.csr.vma    = kb[1];
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: sample handshake before the edge, update the model after it.
  task automatic step(output bit acc);
    bit     fl;
    v_req_t e;
    @(negedge clock);
    acc = enq_valid && enq_ready;
    fl  = flush || reset;
    e   = drv;
    @(posedge clock);
    if (fl)  exp_q.delete();
    if (acc) exp_q.push_back(e);
    #1;
  endtask

  task automatic tick(int n);
    bit a;
    for (int i = 0; i < n; i++) step(a);
  endtask

  // Monitor: every issue fire must match the oldest expected entry.
  always @(negedge clock) begin
    v_req_t act, e;
    if (!reset && req_valid && req_ready) begin
      act.inst       = req_bits_inst;
      act.src1Data   = req_bits_src1Data;
      act.csr.vl     = csr_vl;
      act.csr.vStart = csr_vStart;
      act.csr.vlmul  = csr_vlmul;
      act.csr.vSew   = csr_vSew;
      act.csr.vxrm   = csr_vxrm;
      act.csr.vta    = csr_vta;
      act.csr.vma    = csr_vma;
      issued++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL issue_unexpected: got inst 0x%0h expected no issue", act.inst);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          n_fail++;
          $display("FAIL issue_data: got 0x%0h expected 0x%0h", act, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int n, guard, base;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_enq_ready", 32'(enq_ready), 0);
    chk("rst_req_valid", 32'(req_valid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_outstanding", 32'(outstanding), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err_unexpectedResp), 0);
    reset = 1'b0;
    #1;
    chk("post_rst_enq_ready", 32'(enq_ready), 1);

    // Single request round trip
    drv = mk(32'h0000_5057, 32'h1234, 0);
    drv.csr.vl = 10'd16; drv.csr.vSew = 2'd2;
    enq_valid = 1'b1; req_ready = 1'b1;
    step(acc);
    enq_valid = 1'b0;
    chk("t1_req_valid", 32'(req_valid), 1);
    chk("t1_count", 32'(count), 1);
    tick(1);
    chk("t1_outstanding", 32'(outstanding), 1);
    chk("t1_req_valid_after", 32'(req_valid), 0);
    resp_valid = 1'b1; tick(1); resp_valid = 1'b0;
    chk("t1_outstanding_resp", 32'(outstanding), 0);
    chk("t1_busy", 32'(busy), 0);

    // Fill to full with V stalled, then drain in order
    req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drv = mk(32'h100 + 32'(i), 32'hA000 + 32'(i), i + 1);
      enq_valid = 1'b1;
      step(acc);
      if (i == 3) begin
        chk("t2_count_full", 32'(count), 4);
        chk("t2_enq_ready_full", 32'(enq_ready), 0);
      end
    end
    enq_valid = 1'b0;
    chk("t2_count_after5", 32'(count), 4);
    req_ready = 1'b1;
    tick(1);
    chk("t2_count_pop1", 32'(count), 3);
    chk("t2_enq_ready_back", 32'(enq_ready), 1);
    tick(3);
    chk("t2_count_drained", 32'(count), 0);
    chk("t2_outstanding", 32'(outstanding), 4);
    resp_valid = 1'b1; tick(4); resp_valid = 1'b0;
    chk("t2_outstanding_resp", 32'(outstanding), 0);

    // Credit limit
    base = issued;
    n = 0; guard = 0;
    while (n < 10 && guard < 60) begin
      drv = mk(32'h200 + 32'(n), 32'hB000 + 32'(n), n + 7);
      enq_valid = 1'b1;
      step(acc);
      if (acc) n++;
      guard++;
    end
    enq_valid = 1'b0;
    chk("t3_all_enqueued", 32'(n), 10);
    tick(2);
    chk("t3_issued", 32'(issued - base), 8);
    chk("t3_outstanding_max", 32'(outstanding), 8);
    chk("t3_count", 32'(count), 2);
    chk("t3_req_valid_blocked", 32'(req_valid), 0);
    resp_valid = 1'b1; tick(1); resp_valid = 1'b0;
    chk("t3_req_valid_credit", 32'(req_valid), 1);
    tick(1);
    chk("t3_issued9", 32'(issued - base), 9);
    chk("t3_outstanding_again", 32'(outstanding), 8);
    resp_valid = 1'b1; tick(9); resp_valid = 1'b0;
    chk("t3_drain_outstanding", 32'(outstanding), 0);
    chk("t3_drain_count", 32'(count), 0);
    chk("t3_no_err", 32'(err_unexpectedResp), 0);

    // Flush with pending enq
    req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drv = mk(32'h300 + 32'(i), 32'hC000 + 32'(i), i + 3);
      enq_valid = 1'b1;
      step(acc);
    end
    enq_valid = 1'b0; req_ready = 1'b1;
    tick(2);
    req_ready = 1'b0;
    drv = mk(32'h304, 32'hC004, 9);
    enq_valid = 1'b1;
    step(acc);
    chk("t4_count_pre", 32'(count), 3);
    chk("t4_outstanding_pre", 32'(outstanding), 2);
    drv = mk(32'h305, 32'hC005, 10);
    flush = 1'b1;
    #1;
    chk("t4_enq_ready_flush", 32'(enq_ready), 0);
    step(acc);
    flush = 1'b0; enq_valid = 1'b0;
    chk("t4_count", 32'(count), 0);
    chk("t4_outstanding", 32'(outstanding), 2);
    chk("t4_busy", 32'(busy), 1);
    chk("t4_req_valid", 32'(req_valid), 0);

    // Simultaneous issue and response, then unexpected response
    req_ready = 1'b1;
    drv = mk(32'h400, 32'hD000, 11);
    enq_valid = 1'b1; step(acc); enq_valid = 1'b0;
    tick(1);
    chk("t5_outstanding3", 32'(outstanding), 3);
    drv = mk(32'h401, 32'hD001, 12);
    enq_valid = 1'b1; step(acc); enq_valid = 1'b0;
    resp_valid = 1'b1; tick(1);
    chk("t5_issue_resp_same", 32'(outstanding), 3);
    chk("t5_count", 32'(count), 0);
    tick(3); resp_valid = 1'b0;
    chk("t5_outstanding0", 32'(outstanding), 0);
    chk("t5_err_clear", 32'(err_unexpectedResp), 0);
    resp_valid = 1'b1; tick(1); resp_valid = 1'b0;
    chk("t5_err_set", 32'(err_unexpectedResp), 1);
    chk("t5_outstanding_stays0", 32'(outstanding), 0);
    flush = 1'b1; tick(1); flush = 1'b0;
    tick(2);
    chk("t5_err_sticky", 32'(err_unexpectedResp), 1);

    // Mid-operation reset
    req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drv = mk(32'h500 + 32'(i), 32'hE000 + 32'(i), i + 2);
      enq_valid = 1'b1; step(acc);
    end
    enq_valid = 1'b0; req_ready = 1'b1;
    tick(4);
    req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drv = mk(32'h600 + 32'(i), 32'hF000 + 32'(i), i + 5);
      enq_valid = 1'b1; step(acc);
    end
    enq_valid = 1'b0;
    chk("t6_count_pre", 32'(count), 2);
    chk("t6_outstanding_pre", 32'(outstanding), 4);
    reset = 1'b1; tick(1); reset = 1'b0;
    #1;
    chk("t6_count", 32'(count), 0);
    chk("t6_outstanding", 32'(outstanding), 0);
    chk("t6_req_valid", 32'(req_valid), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_err_cleared", 32'(err_unexpectedResp), 0);
    chk("t6_enq_ready", 32'(enq_ready), 1);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
